// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Multi-cycle ALU with registered result and CF/ZF/SF/OF flags.
//            Define SEQ_ALU_FAST_SHIFT_EN for single-cycle barrel shifts.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             wb_en,
    output logic [WIDTH-1:0] result,
    output logic             cf,
    output logic             zf,
    output logic             sf,
    output logic             of
);
    localparam logic [4:0] c_fn_add = 5'b00001;
    localparam logic [4:0] c_fn_and = 5'b00010;
    localparam logic [4:0] c_fn_sub = 5'b00011;
    localparam logic [4:0] c_fn_or  = 5'b00100;
    localparam logic [4:0] c_fn_xor = 5'b00101;
    localparam logic [4:0] c_fn_mov = 5'b00110;
    localparam logic [4:0] c_fn_not = 5'b01000;
    localparam logic [4:0] c_fn_sar = 5'b01001;
    localparam logic [4:0] c_fn_slr = 5'b01010;
    localparam logic [4:0] c_fn_sal = 5'b01011;
    localparam logic [4:0] c_fn_sll = 5'b01100;
    localparam logic [4:0] c_fn_rol = 5'b01101;
    localparam logic [4:0] c_fn_ror = 5'b01110;
    localparam logic [4:0] c_fn_inc = 5'b01111;
    localparam logic [4:0] c_fn_dec = 5'b10000;
    localparam logic [4:0] c_fn_cmp = 5'b10100;
    localparam int         c_msb    = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         func_q, func_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cf_q, cf_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
    logic               wb_en_q, wb_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   w_add_b, w_sub_b;
    logic [WIDTH:0]     w_sum, w_diff;
    logic               w_add_of, w_sub_of;
    logic               w_is_left;
    logic [WIDTH-1:0]   w_sh_res;
    logic               w_sh_cf;
    logic               w_zs;
    logic [WIDTH-1:0]   w_zs_val;

    assign w_add_b   = (func_q == c_fn_inc) ? WIDTH'(1) : opb_q;
    assign w_sub_b   = (func_q == c_fn_dec) ? WIDTH'(1) : opb_q;
    assign w_sum     = {1'b0, opa_q} + {1'b0, w_add_b};
    assign w_diff    = {1'b0, opa_q} - {1'b0, w_sub_b};
    assign w_add_of  = (opa_q[c_msb] == w_add_b[c_msb]) & (w_sum[c_msb] != opa_q[c_msb]);
    assign w_sub_of  = (opa_q[c_msb] != w_sub_b[c_msb]) & (w_diff[c_msb] != opa_q[c_msb]);
    assign w_is_left = (func_q == c_fn_sll) || (func_q == c_fn_sal);

`ifdef SEQ_ALU_FAST_SHIFT_EN
    logic [CNT_W-1:0]   w_sh_cnt, w_cnt_m1;
    logic [WIDTH-1:0]   w_left_tmp, w_right_tmp;
    logic [2*WIDTH-1:0] w_rol_full, w_ror_full;

    assign w_sh_cnt    = opb_q[CNT_W-1:0];
    assign w_cnt_m1    = w_sh_cnt - CNT_W'(1);
    assign w_left_tmp  = opa_q << w_cnt_m1;
    assign w_right_tmp = opa_q >> w_cnt_m1;
    assign w_rol_full  = {opa_q, opa_q} << w_sh_cnt;
    assign w_ror_full  = {opa_q, opa_q} >> w_sh_cnt;

    // CF is the last bit moved out, taken from a copy shifted one place less.
    always_comb begin
        w_sh_res = opa_q;
        w_sh_cf  = cf_q;
        if (w_sh_cnt != '0) begin
            case (func_q)
                c_fn_sal, c_fn_sll: begin
                    w_sh_res = opa_q << w_sh_cnt;
                    w_sh_cf  = w_left_tmp[c_msb];
                end
                c_fn_slr: begin
                    w_sh_res = opa_q >> w_sh_cnt;
                    w_sh_cf  = w_right_tmp[0];
                end
                c_fn_sar: begin
                    w_sh_res = $signed(opa_q) >>> w_sh_cnt;
                    w_sh_cf  = w_right_tmp[0];
                end
                c_fn_rol: begin
                    w_sh_res = w_rol_full[2*WIDTH-1:WIDTH];
                    w_sh_cf  = w_rol_full[WIDTH];
                end
                c_fn_ror: begin
                    w_sh_res = w_ror_full[WIDTH-1:0];
                    w_sh_cf  = w_ror_full[WIDTH-1];
                end
                default: ;
            endcase
        end
    end
`else
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   w_step_res;
    logic               w_step_cf;

    // Shifts reach CALC only with a zero count in the iterative build.
    assign w_sh_res = opa_q;
    assign w_sh_cf  = cf_q;

    always_comb begin
        w_step_res = work_q;
        w_step_cf  = 1'b0;
        case (func_q)
            c_fn_sal, c_fn_sll: begin
                w_step_res = {work_q[c_msb-1:0], 1'b0};
                w_step_cf  = work_q[c_msb];
            end
            c_fn_slr: begin
                w_step_res = {1'b0, work_q[c_msb:1]};
                w_step_cf  = work_q[0];
            end
            c_fn_sar: begin
                w_step_res = {work_q[c_msb], work_q[c_msb:1]};
                w_step_cf  = work_q[0];
            end
            c_fn_rol: begin
                w_step_res = {work_q[c_msb-1:0], work_q[c_msb]};
                w_step_cf  = work_q[c_msb];
            end
            c_fn_ror: begin
                w_step_res = {work_q[0], work_q[c_msb:1]};
                w_step_cf  = work_q[0];
            end
            default: ;
        endcase
    end

    function automatic logic is_shift(input logic [4:0] f);
        return (f >= c_fn_sar) && (f <= c_fn_ror);
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cf_d     = cf_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        of_d     = of_q;
        wb_en_d  = 1'b0;
        w_zs     = 1'b0;
        w_zs_val = result_q;
`ifndef SEQ_ALU_FAST_SHIFT_EN
        work_d   = work_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    func_d  = func;
                    opa_d   = a;
                    opb_d   = b;
                    state_d = S_CALC;
`ifndef SEQ_ALU_FAST_SHIFT_EN
                    work_d  = a;
                    cnt_d   = b[CNT_W-1:0];
                    if (is_shift(func) && (b[CNT_W-1:0] != '0)) begin
                        state_d = S_SHIFT;
                    end
`endif
                end
            end
            S_CALC: begin
                state_d = S_DONE;
                case (func_q)
                    c_fn_add, c_fn_inc: begin
                        result_d = w_sum[WIDTH-1:0];
                        cf_d     = w_sum[WIDTH];
                        of_d     = w_add_of;
                        w_zs     = 1'b1;
                        w_zs_val = w_sum[WIDTH-1:0];
                        wb_en_d  = 1'b1;
                    end
                    c_fn_sub, c_fn_dec, c_fn_cmp: begin
                        if (func_q != c_fn_cmp) begin
                            result_d = w_diff[WIDTH-1:0];
                            wb_en_d  = 1'b1;
                        end
                        cf_d     = w_diff[WIDTH];
                        of_d     = w_sub_of;
                        w_zs     = 1'b1;
                        w_zs_val = w_diff[WIDTH-1:0];
                    end
                    c_fn_and, c_fn_or, c_fn_xor: begin
                        if (func_q == c_fn_and)     w_zs_val = opa_q & opb_q;
                        else if (func_q == c_fn_or) w_zs_val = opa_q | opb_q;
                        else                        w_zs_val = opa_q ^ opb_q;
                        result_d = w_zs_val;
                        cf_d     = 1'b0;
                        of_d     = 1'b0;
                        w_zs     = 1'b1;
                        wb_en_d  = 1'b1;
                    end
                    c_fn_mov: begin
                        result_d = opb_q;
                        wb_en_d  = 1'b1;
                    end
                    c_fn_not: begin
                        result_d = ~opa_q;
                        wb_en_d  = 1'b1;
                    end
                    c_fn_sar, c_fn_slr, c_fn_sal, c_fn_sll, c_fn_rol, c_fn_ror: begin
                        result_d = w_sh_res;
                        cf_d     = w_sh_cf;
                        of_d     = w_is_left & (w_sh_res[c_msb] ^ opa_q[c_msb]);
                        w_zs     = 1'b1;
                        w_zs_val = w_sh_res;
                        wb_en_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
`ifndef SEQ_ALU_FAST_SHIFT_EN
            S_SHIFT: begin
                work_d = w_step_res;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = w_step_res;
                    cf_d     = w_step_cf;
                    of_d     = w_is_left & (w_step_res[c_msb] ^ opa_q[c_msb]);
                    w_zs     = 1'b1;
                    w_zs_val = w_step_res;
                    wb_en_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (w_zs) begin
            zf_d = (w_zs_val == '0);
            sf_d = w_zs_val[c_msb];
        end
        busy_d = (state_d == S_CALC) || (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            func_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
            wb_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
            work_q   <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cf_q     <= cf_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            of_q     <= of_d;
            wb_en_q  <= wb_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifndef SEQ_ALU_FAST_SHIFT_EN
            work_q   <= work_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign wb_en  = wb_en_q;
    assign result = result_q;
    assign cf     = cf_q;
    assign zf     = zf_q;
    assign sf     = sf_q;
    assign of     = of_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=8; expected results are
// queued at issue time from an integer reference model and popped on done.
module tb_seq_alu;
    localparam int W = 8;
    localparam logic [4:0] F_NOP = 5'b00000, F_ADD = 5'b00001, F_AND = 5'b00010;
    localparam logic [4:0] F_SUB = 5'b00011, F_OR  = 5'b00100, F_XOR = 5'b00101;
    localparam logic [4:0] F_MOV = 5'b00110, F_NOT = 5'b01000, F_SAR = 5'b01001;
    localparam logic [4:0] F_SLR = 5'b01010, F_SAL = 5'b01011, F_SLL = 5'b01100;
    localparam logic [4:0] F_ROL = 5'b01101, F_ROR = 5'b01110, F_INC = 5'b01111;
    localparam logic [4:0] F_DEC = 5'b10000, F_CMP = 5'b10100;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [4:0]   func;
    logic [W-1:0] a, b;
    logic         busy, done, wb_en;
    logic [W-1:0] result;
    logic         cf, zf, sf, of;

    typedef struct {
        logic [W-1:0] res;
        logic         cf, zf, sf, of, wb;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] m_res;
    logic         m_cf, m_zf, m_sf, m_of;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .a(a), .b(b),
        .busy(busy), .done(done), .wb_en(wb_en), .result(result),
        .cf(cf), .zf(zf), .sf(sf), .of(of)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [4:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int ux, uy, sx, sy, s, v, n, c;
        bit fl, wr;
        ux = int'(x); uy = int'(y);
        v = 0; n = 0; c = 0; fl = 0; wr = 0;
        e.lat = 1;
        case (f)
            F_ADD, F_INC: begin
                if (f == F_INC) uy = 1;
                sx = (ux > 127) ? ux - 256 : ux;
                sy = (uy > 127) ? uy - 256 : uy;
                s = ux + uy; v = s % 256;
                m_cf = (s > 255);
                m_of = (sx + sy > 127) || (sx + sy < -128);
                fl = 1; wr = 1;
            end
            F_SUB, F_DEC, F_CMP: begin
                if (f == F_DEC) uy = 1;
                sx = (ux > 127) ? ux - 256 : ux;
                sy = (uy > 127) ? uy - 256 : uy;
                v = (ux - uy + 256) % 256;
                m_cf = (ux < uy);
                m_of = (sx - sy > 127) || (sx - sy < -128);
                fl = 1; wr = (f != F_CMP);
            end
            F_AND, F_OR, F_XOR: begin
                v = (f == F_AND) ? (ux & uy) : (f == F_OR) ? (ux | uy) : (ux ^ uy);
                m_cf = 1'b0; m_of = 1'b0; fl = 1; wr = 1;
            end
            F_MOV: begin v = uy; wr = 1; end
            F_NOT: begin v = 255 - ux; wr = 1; end
            F_SAR, F_SLR, F_SAL, F_SLL, F_ROL, F_ROR: begin
                n = uy % 8; v = ux;
                for (int i = 0; i < n; i++) begin
                    case (f)
                        F_SAL, F_SLL: begin c = (v >> 7) & 1; v = (v << 1) & 255; end
                        F_SLR:        begin c = v & 1; v = v >> 1; end
                        F_SAR:        begin c = v & 1; v = (v >> 1) | (v & 128); end
                        F_ROL:        begin c = (v >> 7) & 1; v = ((v << 1) | c) & 255; end
                        default:      begin c = v & 1; v = (v >> 1) | (c << 7); end
                    endcase
                end
                if (n != 0) m_cf = (c != 0);
                m_of = ((f == F_SLL) || (f == F_SAL)) && (((v ^ ux) & 128) != 0);
`ifndef SEQ_ALU_FAST_SHIFT_EN
                e.lat = (n == 0) ? 1 : n;
`endif
                fl = 1; wr = 1;
            end
            default: ;
        endcase
        if (fl) begin
            m_zf = (v == 0);
            m_sf = (v > 127);
        end
        if (wr) m_res = v[W-1:0];
        e.res = m_res; e.cf = m_cf; e.zf = m_zf; e.sf = m_sf; e.of = m_of; e.wb = wr;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [4:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; func = f; a = x; b = y;
        push_expected(f, x, y);
    endtask

    // Entered #1 after the accepting edge; lat0 edges have already elapsed.
    task automatic await_and_score(input int lat0);
        exp_t e;
        int lat;
        lat = lat0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        check("done_seen", 64'(done), 64'(1));
        if (done) begin
            check("busy_with_done", 64'(busy), 64'(0));
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                check("result",  64'(result), 64'(e.res));
                check("cf",      64'(cf),     64'(e.cf));
                check("zf",      64'(zf),     64'(e.zf));
                check("sf",      64'(sf),     64'(e.sf));
                check("of",      64'(of),     64'(e.of));
                check("wb_en",   64'(wb_en),  64'(e.wb));
                check("latency", 64'(lat),    64'(e.lat));
            end
        end
    endtask

    task automatic do_op(input logic [4:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        issue(f, x, y);
        tick();
        start = 1'b0;
        await_and_score(0);
        tick();
    endtask

    logic [4:0] codes [19] = '{F_NOP, F_ADD, F_AND, F_SUB, F_OR, F_XOR, F_MOV, F_NOT,
                               F_SAR, F_SLR, F_SAL, F_SLL, F_ROL, F_ROR, F_INC, F_DEC,
                               F_CMP, 5'b00111, 5'b11111};

    initial begin
        rst = 1'b0; start = 1'b0; func = '0; a = '0; b = '0;
        m_res = '0; m_cf = 1'b0; m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, done, wb_en, result, cf, zf, sf, of}), 64'(0));
        rst = 1'b1;
        tick();

        do_op(F_ADD, 8'h7F, 8'h01);
        do_op(F_SUB, 8'h10, 8'h20);
        do_op(F_CMP, 8'h05, 8'h05);
        do_op(F_ROL, 8'h81, 8'h03);
        do_op(F_SAR, 8'h90, 8'h02);
        do_op(F_SLL, 8'h55, 8'h08);
        do_op(F_SLL, 8'hC3, 8'h03);
        do_op(F_SLR, 8'hA5, 8'h04);
        do_op(F_ROR, 8'h01, 8'h01);
        do_op(F_AND, 8'hF0, 8'h0F);
        do_op(F_MOV, 8'h3C, 8'hA7);
        do_op(F_NOT, 8'h3C, 8'h00);
        do_op(F_NOP, 8'h11, 8'h22);
        do_op(5'b00111, 8'h11, 8'h22);
        do_op(F_DEC, 8'h80, 8'h00);

        // start held through CALC (ignored) and DONE (accepted back-to-back)
        issue(F_ADD, 8'h7F, 8'h01);
        tick();
        issue(F_SUB, 8'h10, 8'h20);
        await_and_score(0);
        tick();
        start = 1'b0;
        check("b2b_no_bubble", 64'({busy, done}), 64'(2'b10));
        await_and_score(0);
        tick();

        // ADD request while a shift is running must be dropped
        issue(F_ROL, 8'h81, 8'h03);
        tick();
        start = 1'b1; func = F_ADD; a = 8'h01; b = 8'h01;
        tick();
        start = 1'b0;
        await_and_score(1);
        tick();
        check("idle_after_ignored", 64'({busy, done, result}), 64'({2'b00, 8'h0C}));

        // asynchronous reset in the middle of a 5-step rotate
        issue(F_ROR, 8'hB3, 8'h05);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 64'({busy, done, wb_en, result, cf, zf, sf, of}), 64'(0));
        sb.delete();
        m_res = '0; m_cf = 1'b0; m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        do_op(F_INC, 8'hFF, 8'h00);

        for (int i = 0; i < 24; i++) begin
            do_op(codes[$urandom_range(0, 18)], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
